// File: rtl/dlc_bank_ctrl.sv
// dlc_bank_ctrl: round-robin arbiter and strobe sequencer for a shared bank of gated latches.
// Define DLC_BANK_CLR_EN to compile in the bank clear path (CLR_REQ, LAT_CLEAR, CLR_DONE).
module dlc_bank_ctrl #(
  parameter int NREQ      = 2,
  parameter int NLAT      = 4,
  parameter int W         = 8,
  parameter int AW        = 4,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2,
  parameter int HOLD_CYC  = 1,
  parameter int CLR_CYC   = 2
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ*AW-1:0]   REQ_ADDR,
  input  logic [NREQ*W-1:0]    REQ_DATA,
  output logic [NREQ-1:0]      ACK,
  input  logic                 CLR_REQ,
  output logic                 CLR_DONE,
  output logic [W-1:0]         LAT_D,
  output logic [NLAT-1:0]      LAT_G,
  output logic                 LAT_CLEAR,
  output logic                 BUSY
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int CW = 8;

  typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, ACKW, CLEAR, CDONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rrPtr_q, rrPtr_d;
  logic [PW-1:0] grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [W-1:0]  data_q, data_d;
  logic          clrPend_q, clrPend_d;
  logic          clrReq;
  logic          clrSeen;
  logic          anyReq;
  logic [PW-1:0] pick;
  logic [AW-1:0] pickAddr;
  logic [W-1:0]  pickData;
  int            bestDist;

`ifdef DLC_BANK_CLR_EN
  assign clrReq = CLR_REQ;
`else
  logic unusedClrReq;
  assign unusedClrReq = CLR_REQ;
  assign clrReq       = 1'b0;
`endif

  // A raw CLR_REQ seen in IDLE counts as pending, so a clear beats a write arriving on the same edge.
  assign clrSeen = clrPend_q | clrReq;

  always_comb begin
    pick     = '0;
    pickAddr = '0;
    pickData = '0;
    anyReq   = 1'b0;
    bestDist = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (REQ[i] && (((i - int'(rrPtr_q) + NREQ) % NREQ) < bestDist)) begin
        bestDist = (i - int'(rrPtr_q) + NREQ) % NREQ;
        pick     = PW'(i);
        pickAddr = REQ_ADDR[i*AW +: AW];
        pickData = REQ_DATA[i*W +: W];
        anyReq   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    data_d    = data_q;
    clrPend_d = clrPend_q | clrReq;
    case (state_q)
      IDLE: begin
        if (clrSeen) begin
          state_d   = CLEAR;
          cnt_d     = '0;
          clrPend_d = 1'b0;
        end else if (anyReq) begin
          state_d = SETUP;
          cnt_d   = '0;
          grant_d = pick;
          addr_d  = pickAddr;
          data_d  = pickData;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = GATE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GATE: begin
        if (cnt_q == CW'(GATE_CYC - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = ACKW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACKW: begin
        state_d = IDLE;
        rrPtr_d = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;
      end
      CLEAR: begin
        if (cnt_q == CW'(CLR_CYC - 1)) begin
          state_d = CDONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      clrPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      clrPend_q <= clrPend_d;
    end
  end

  // Out-of-range addresses match no gate bit, so the sequence runs with LAT_G all zero.
  always_comb begin
    for (int i = 0; i < NREQ; i++) ACK[i] = (state_q == ACKW) && (int'(grant_q) == i);
    for (int n = 0; n < NLAT; n++) LAT_G[n] = (state_q == GATE) && (int'(addr_q) == n);
  end

  assign LAT_D = data_q;
  assign BUSY  = (state_q != IDLE);

`ifdef DLC_BANK_CLR_EN
  assign LAT_CLEAR = (state_q == CLEAR);
  assign CLR_DONE  = (state_q == CDONE);
`else
  assign LAT_CLEAR = 1'b0;
  assign CLR_DONE  = 1'b0;
`endif

endmodule
